// File: rtl/tmds_pkg.sv
// TMDS receive-side symbol tables, mode codes and decode helpers.
// Shared by the per-channel decoder and the sink-level preamble logic.
package tmds_pkg;

    localparam logic [2:0] MODE_CONTROL      = 3'd0;
    localparam logic [2:0] MODE_VIDEO        = 3'd1;
    localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
    localparam logic [2:0] MODE_ISLAND       = 3'd3;
    localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam logic [9:0] VIDEO_GUARD_CN02 = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CN1  = 10'b0100110011;
    localparam logic [9:0] DATA_GUARD       = 10'b0100110011;

    localparam logic [3:0] PREAMBLE_FULL = 4'd8;
    localparam logic [4:0] MAX_PACKETS   = 5'd18;

    typedef enum logic [2:0] {
        CONTROL,
        VID_GB,
        VIDEO,
        DI_LEAD_GB,
        ISLAND,
        DI_TRAIL_GB
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } terc4_t;

    function automatic logic is_control(input logic [9:0] s);
        return s == CTRL_00 || s == CTRL_01 ||
               s == CTRL_10 || s == CTRL_11;
    endfunction

    function automatic logic [1:0] control_decode(input logic [9:0] s);
        logic [1:0] c;
        case (s)
            CTRL_01: c = 2'b01;
            CTRL_10: c = 2'b10;
            CTRL_11: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    function automatic terc4_t terc4_decode(input logic [9:0] s);
        terc4_t r;
        r.valid  = 1'b1;
        r.nibble = 4'h0;
        case (s)
            10'b1010011100: r.nibble = 4'h0;
            10'b1001100011: r.nibble = 4'h1;
            10'b1011100100: r.nibble = 4'h2;
            10'b1011100010: r.nibble = 4'h3;
            10'b0101110001: r.nibble = 4'h4;
            10'b0100011110: r.nibble = 4'h5;
            10'b0110001110: r.nibble = 4'h6;
            10'b0100111100: r.nibble = 4'h7;
            10'b1011001100: r.nibble = 4'h8;
            10'b0100111001: r.nibble = 4'h9;
            10'b0110011100: r.nibble = 4'hA;
            10'b1011000110: r.nibble = 4'hB;
            10'b1010001110: r.nibble = 4'hC;
            10'b1001110001: r.nibble = 4'hD;
            10'b0101100011: r.nibble = 4'hE;
            10'b1011000011: r.nibble = 4'hF;
            default:        r.valid  = 1'b0;
        endcase
        return r;
    endfunction

    // Undo the optional inversion, then the XOR/XNOR chain.
    function automatic logic [7:0] video_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        q = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction

    // CTL0/CTL1 ride on channel 1, CTL2/CTL3 on channel 2.
    function automatic logic [1:0] preamble_decode(
        input logic [9:0] ch1,
        input logic [9:0] ch2
    );
        logic [3:0] ctl;
        if (!is_control(ch1) || !is_control(ch2))
            return 2'b00;
        ctl = {control_decode(ch2), control_decode(ch1)};
        case (ctl)
            4'b0001: return 2'b01;
            4'b0101: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic is_video_guard(input int cn, input logic [9:0] s);
        return (cn == 1) ? (s == VIDEO_GUARD_CN1) : (s == VIDEO_GUARD_CN02);
    endfunction

    // Channel 0 guards carry hsync/vsync, so they are TERC4 symbols.
    function automatic logic is_data_guard(input int cn, input logic [9:0] s);
        terc4_t t;
        t = terc4_decode(s);
        if (cn == 0)
            return t.valid && t.nibble[3:2] == 2'b11;
        return s == DATA_GUARD;
    endfunction

    function automatic logic is_trail_guard(input int cn, input logic [9:0] s);
        terc4_t t;
        t = terc4_decode(s);
        if (cn == 0)
            return t.valid && t.nibble[3];
        return s == DATA_GUARD;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS decoder tracking control/video/data-island periods.
// Ports: clk_pixel, reset (sync, high), tmds[9:0], preamble[1:0] in;
// mode[2:0], video_data[7:0], data_island_data[3:0], control_data[1:0],
// decode_error out. All outputs registered, one cycle after tmds.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CN = 0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [9:0] tmds,
    input  logic [1:0] preamble,
    output logic [2:0] mode,
    output logic [7:0] video_data,
    output logic [3:0] data_island_data,
    output logic [1:0] control_data,
    output logic       decode_error
);

    state_t     state, state_n;
    logic [3:0] pre_cnt, pre_cnt_n;
    logic [1:0] prev_pre;
    logic [4:0] sym_cnt, sym_cnt_n;
    logic [4:0] pkt_cnt, pkt_cnt_n;

    logic [2:0] mode_n;
    logic [7:0] video_n;
    logic [3:0] island_n;
    logic [1:0] control_n;
    logic       error_n;

    logic   ctl;
    logic   vguard;
    logic   dguard;
    logic   tguard;
    terc4_t t4;
    logic   pre_video;
    logic   pre_island;

    assign ctl    = is_control(tmds);
    assign vguard = is_video_guard(CN, tmds);
    assign dguard = is_data_guard(CN, tmds);
    assign tguard = is_trail_guard(CN, tmds);
    assign t4     = terc4_decode(tmds);

    assign pre_video  = pre_cnt == PREAMBLE_FULL && prev_pre == 2'b01;
    assign pre_island = pre_cnt == PREAMBLE_FULL && prev_pre == 2'b10;

    // A changed preamble code restarts the run at 1.
    always_comb begin
        pre_cnt_n = 4'd0;
        if (ctl && preamble != 2'b00) begin
            if (preamble != prev_pre)
                pre_cnt_n = 4'd1;
            else if (pre_cnt == PREAMBLE_FULL)
                pre_cnt_n = PREAMBLE_FULL;
            else
                pre_cnt_n = pre_cnt + 4'd1;
        end
    end

    always_comb begin
        state_n   = state;
        sym_cnt_n = sym_cnt;
        pkt_cnt_n = pkt_cnt;
        mode_n    = MODE_CONTROL;
        video_n   = video_data;
        island_n  = data_island_data;
        control_n = control_data;
        error_n   = 1'b0;

        unique case (state)
            CONTROL: begin
                if (ctl) begin
                    control_n = control_decode(tmds);
                end else if (pre_video && vguard) begin
                    state_n = VID_GB;
                    mode_n  = MODE_VIDEO_GUARD;
                end else if (pre_island && dguard) begin
                    state_n = DI_LEAD_GB;
                    mode_n  = MODE_ISLAND_GUARD;
                    if (CN == 0) begin
                        island_n  = t4.nibble;
                        control_n = t4.nibble[1:0];
                    end
                end else begin
                    error_n = 1'b1;
                end
            end
            VID_GB: begin
                if (vguard) begin
                    state_n = VIDEO;
                    mode_n  = MODE_VIDEO_GUARD;
                end else begin
                    state_n = CONTROL;
                    error_n = 1'b1;
                end
            end
            VIDEO: begin
                if (ctl) begin
                    state_n   = CONTROL;
                    control_n = control_decode(tmds);
                end else begin
                    mode_n  = MODE_VIDEO;
                    video_n = video_decode(tmds);
                end
            end
            DI_LEAD_GB: begin
                if (dguard) begin
                    state_n   = ISLAND;
                    sym_cnt_n = 5'd0;
                    pkt_cnt_n = 5'd0;
                    mode_n    = MODE_ISLAND_GUARD;
                    if (CN == 0) begin
                        island_n  = t4.nibble;
                        control_n = t4.nibble[1:0];
                    end
                end else begin
                    state_n = CONTROL;
                    error_n = 1'b1;
                end
            end
            ISLAND: begin
                // Packet boundary: either a trailing guard or a new packet.
                if (sym_cnt == 5'd0 && pkt_cnt != 5'd0 && tguard) begin
                    state_n = DI_TRAIL_GB;
                    mode_n  = MODE_ISLAND_GUARD;
                    if (CN == 0) begin
                        island_n  = t4.nibble;
                        control_n = t4.nibble[1:0];
                    end
                end else if (!t4.valid ||
                             (sym_cnt == 5'd0 && pkt_cnt == MAX_PACKETS)) begin
                    state_n = CONTROL;
                    error_n = 1'b1;
                end else begin
                    mode_n    = MODE_ISLAND;
                    island_n  = t4.nibble;
                    sym_cnt_n = sym_cnt + 5'd1;
                    if (sym_cnt == 5'd31)
                        pkt_cnt_n = pkt_cnt + 5'd1;
                end
            end
            DI_TRAIL_GB: begin
                state_n = CONTROL;
                if (tguard) begin
                    mode_n = MODE_ISLAND_GUARD;
                    if (CN == 0) begin
                        island_n  = t4.nibble;
                        control_n = t4.nibble[1:0];
                    end
                end else begin
                    error_n = 1'b1;
                end
            end
            default: begin
                state_n = CONTROL;
            end
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state            <= CONTROL;
            pre_cnt          <= 4'd0;
            prev_pre         <= 2'b00;
            sym_cnt          <= 5'd0;
            pkt_cnt          <= 5'd0;
            mode             <= MODE_CONTROL;
            video_data       <= 8'd0;
            data_island_data <= 4'd0;
            control_data     <= 2'd0;
            decode_error     <= 1'b0;
        end else begin
            state            <= state_n;
            pre_cnt          <= pre_cnt_n;
            prev_pre         <= preamble;
            sym_cnt          <= sym_cnt_n;
            pkt_cnt          <= pkt_cnt_n;
            mode             <= mode_n;
            video_data       <= video_n;
            data_island_data <= island_n;
            control_data     <= control_n;
            decode_error     <= error_n;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder, channels 0 and 1 in parallel.
// Both instances see the same symbol stream; each test checks one.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] tmds;
    logic [1:0] preamble;

    logic [2:0] mode0, mode1;
    logic [7:0] vid0, vid1;
    logic [3:0] di0, di1;
    logic [1:0] ctl0, ctl1;
    logic       err0, err1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] t4 [16];
    logic [9:0] ctab [4];

    localparam logic [9:0] C0  = 10'b1101010100;
    localparam logic [9:0] VG0 = 10'b1011001100;
    localparam logic [9:0] DG1 = 10'b0100110011;
    localparam logic [9:0] V00 = 10'b0100000000;
    localparam logic [9:0] VFF = 10'b1000000000;

    always #5 clk = ~clk;

    tmds_channel_decoder #(.CN(0)) u_cn0 (
        .clk_pixel        (clk),
        .reset            (reset),
        .tmds             (tmds),
        .preamble         (preamble),
        .mode             (mode0),
        .video_data       (vid0),
        .data_island_data (di0),
        .control_data     (ctl0),
        .decode_error     (err0)
    );

    tmds_channel_decoder #(.CN(1)) u_cn1 (
        .clk_pixel        (clk),
        .reset            (reset),
        .tmds             (tmds),
        .preamble         (preamble),
        .mode             (mode1),
        .video_data       (vid1),
        .data_island_data (di1),
        .control_data     (ctl1),
        .decode_error     (err1)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
    endtask

    // Present one symbol and sample its registered result.
    task automatic step(input logic [9:0] s, input logic [1:0] p);
        tmds     = s;
        preamble = p;
        @(posedge clk);
        #1;
    endtask

    task automatic pre(input int n, input logic [1:0] p);
        for (int i = 0; i < n; i++)
            step(C0, p);
    endtask

    initial begin
        t4[0]  = 10'b1010011100; t4[1]  = 10'b1001100011;
        t4[2]  = 10'b1011100100; t4[3]  = 10'b1011100010;
        t4[4]  = 10'b0101110001; t4[5]  = 10'b0100011110;
        t4[6]  = 10'b0110001110; t4[7]  = 10'b0100111100;
        t4[8]  = 10'b1011001100; t4[9]  = 10'b0100111001;
        t4[10] = 10'b0110011100; t4[11] = 10'b1011000110;
        t4[12] = 10'b1010001110; t4[13] = 10'b1001110001;
        t4[14] = 10'b0101100011; t4[15] = 10'b1011000011;
        ctab[0] = 10'b1101010100; ctab[1] = 10'b0010101011;
        ctab[2] = 10'b0101010100; ctab[3] = 10'b1010101011;

        reset = 1'b1;
        step(C0, 2'b00);
        step(C0, 2'b00);
        check("rst_mode", 16'(mode0), 16'd0);
        check("rst_vid", 16'(vid0), 16'd0);
        check("rst_di", 16'(di0), 16'd0);
        check("rst_ctl", 16'(ctl0), 16'd0);
        check("rst_err", 16'(err0), 16'd0);
        check("rst_mode1", 16'(mode1), 16'd0);
        reset = 1'b0;

        check("pre_vid", 16'(preamble_decode(ctab[1], ctab[0])), 16'd1);
        check("pre_di", 16'(preamble_decode(ctab[1], ctab[1])), 16'd2);
        check("pre_none", 16'(preamble_decode(ctab[3], ctab[0])), 16'd0);

        for (int i = 0; i < 4; i++) begin
            step(ctab[i], 2'b00);
            check("ctl_mode", 16'(mode0), 16'd0);
            check("ctl_val", 16'(ctl0), 16'(i));
            check("ctl_err", 16'(err0), 16'd0);
        end

        // CN0 video period
        pre(8, 2'b01);
        check("vpre_err", 16'(err0), 16'd0);
        step(VG0, 2'b00);
        check("vgb1_mode", 16'(mode0), 16'd2);
        check("vgb1_err", 16'(err0), 16'd0);
        step(VG0, 2'b00);
        check("vgb2_mode", 16'(mode0), 16'd2);
        step(V00, 2'b00);
        check("v00_mode", 16'(mode0), 16'd1);
        check("v00_data", 16'(vid0), 16'h00);
        step(VFF, 2'b00);
        check("vff_mode", 16'(mode0), 16'd1);
        check("vff_data", 16'(vid0), 16'hFF);
        step(C0, 2'b00);
        check("vend_mode", 16'(mode0), 16'd0);
        check("vend_err", 16'(err0), 16'd0);

        // CN1 data island, one packet
        pre(8, 2'b10);
        for (int i = 0; i < 2; i++) begin
            step(DG1, 2'b00);
            check("dlead1_mode", 16'(mode1), 16'd4);
            check("dlead1_err", 16'(err1), 16'd0);
        end
        for (int i = 0; i < 32; i++) begin
            step(t4[0], 2'b00);
            check("isl1_mode", 16'(mode1), 16'd3);
            check("isl1_di", 16'(di1), 16'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step(DG1, 2'b00);
            check("dtrail1_mode", 16'(mode1), 16'd4);
            check("dtrail1_err", 16'(err1), 16'd0);
        end
        step(C0, 2'b00);
        check("dend1_mode", 16'(mode1), 16'd0);
        check("dend1_err", 16'(err1), 16'd0);

        // CN0 data island, guards carry sync bits
        pre(8, 2'b10);
        step(t4[12], 2'b00);
        check("dlead0_mode", 16'(mode0), 16'd4);
        check("dlead0_di", 16'(di0), 16'hC);
        step(t4[13], 2'b00);
        check("dlead0b_ctl", 16'(ctl0), 16'd1);
        for (int i = 0; i < 32; i++) begin
            step(t4[i % 8], 2'b00);
            check("isl0_di", 16'(di0), 16'(i % 8));
        end
        check("isl0_mode", 16'(mode0), 16'd3);
        step(t4[9], 2'b00);
        check("dtrail0_mode", 16'(mode0), 16'd4);
        check("dtrail0_di", 16'(di0), 16'h9);
        check("dtrail0_ctl", 16'(ctl0), 16'd1);
        step(t4[10], 2'b00);
        check("dtrail0b_mode", 16'(mode0), 16'd4);
        check("dtrail0b_ctl", 16'(ctl0), 16'd2);
        step(ctab[3], 2'b00);
        check("dend0_mode", 16'(mode0), 16'd0);
        check("dend0_ctl", 16'(ctl0), 16'd3);
        check("dend0_err", 16'(err0), 16'd0);

        // CN0 short preamble: guard is illegal
        pre(7, 2'b01);
        step(VG0, 2'b00);
        check("short_err", 16'(err0), 16'd1);
        check("short_mode", 16'(mode0), 16'd0);
        step(C0, 2'b00);
        check("short_err2", 16'(err0), 16'd0);
        check("short_mode2", 16'(mode0), 16'd0);

        // CN1 control symbol inside an island
        pre(8, 2'b10);
        step(DG1, 2'b00);
        step(DG1, 2'b00);
        for (int i = 0; i < 10; i++)
            step(t4[0], 2'b00);
        check("iserr_pre", 16'(mode1), 16'd3);
        step(C0, 2'b00);
        check("iserr_err", 16'(err1), 16'd1);
        check("iserr_mode", 16'(mode1), 16'd0);
        step(ctab[1], 2'b00);
        check("iserr_err2", 16'(err1), 16'd0);
        check("iserr_ctl", 16'(ctl1), 16'd1);

        // CN1 19th packet start with no trailing guard
        pre(8, 2'b10);
        step(DG1, 2'b00);
        step(DG1, 2'b00);
        for (int i = 0; i < 18 * 32; i++)
            step(t4[0], 2'b00);
        check("pmax_mode", 16'(mode1), 16'd3);
        check("pmax_err", 16'(err1), 16'd0);
        step(t4[0], 2'b00);
        check("p19_err", 16'(err1), 16'd1);
        check("p19_mode", 16'(mode1), 16'd0);
        step(C0, 2'b00);

        // Reset in the middle of CN0 video
        pre(8, 2'b01);
        step(VG0, 2'b00);
        step(VG0, 2'b00);
        step(VFF, 2'b00);
        check("rv_mode", 16'(mode0), 16'd1);
        reset = 1'b1;
        step(V00, 2'b00);
        check("rv_rst_mode", 16'(mode0), 16'd0);
        check("rv_rst_vid", 16'(vid0), 16'd0);
        reset = 1'b0;
        step(V00, 2'b00);
        check("rv_mode2", 16'(mode0), 16'd0);
        check("rv_err", 16'(err0), 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
